// File: rtl/wb_sram_pkg.sv
// Shared definitions for the Wishbone-to-asynchronous-SRAM controller.
// Contents:
//   state_t       controller FSM states (IDLE, RD, WR, WR_GAP)
//   CTI_*         Wishbone cycle type identifier codes
//   log2_ceil     ceiling log2, sizes the beat counter
//   beat_bits     beat counter width, never below one bit
package wb_sram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD     = 2'd1,
        WR     = 2'd2,
        WR_GAP = 2'd3
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int beat_bits(input int beats);
        return (beats > 1) ? log2_ceil(beats) : 1;
    endfunction

endpackage

// File: rtl/wb_sram_lane_mux.sv
// Lane steering between the 32-bit Wishbone word and one SRAM beat.
// Ports:
//   wr_beat     beat being loaded onto the SRAM pins
//   rd_beat     beat whose read data is being captured
//   wr_data     Wishbone write word
//   wr_sel      Wishbone byte selects
//   lane_data   write data for wr_beat
//   lane_be_n   active-low byte enables for wr_beat
//   rd_lane_we  byte-lane write enables of wb_dat_o for rd_beat
module wb_sram_lane_mux
    import wb_sram_pkg::*;
#(
    parameter int SRAM_DW = 16,
    parameter int BW      = 1,
    localparam int LANES  = SRAM_DW / 8
) (
    input  logic [BW-1:0]      wr_beat,
    input  logic [BW-1:0]      rd_beat,
    input  logic [31:0]        wr_data,
    input  logic [3:0]         wr_sel,
    output logic [SRAM_DW-1:0] lane_data,
    output logic [LANES-1:0]   lane_be_n,
    output logic [3:0]         rd_lane_we
);

    localparam int BEATS = 32 / SRAM_DW;

    // Pick the lane group addressed by each beat index.
    always_comb begin
        lane_data  = wr_data[SRAM_DW-1:0];
        lane_be_n  = ~wr_sel[LANES-1:0];
        rd_lane_we = 4'b0000;
        for (int b = 0; b < BEATS; b++) begin
            if (wr_beat == BW'(b)) begin
                lane_data = wr_data[b*SRAM_DW +: SRAM_DW];
                lane_be_n = ~wr_sel[b*LANES +: LANES];
            end else begin
                lane_data = lane_data;
                lane_be_n = lane_be_n;
            end
            if (rd_beat == BW'(b)) begin
                rd_lane_we[b*LANES +: LANES] = {LANES{1'b1}};
            end else begin
                rd_lane_we = rd_lane_we;
            end
        end
    end

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone slave to asynchronous SRAM controller. A 32-bit word is split
// into 32/SRAM_DW beats; reads hold each beat RD_LATENCY+1 cycles, writes
// hold we_n low WR_LATENCY+1 cycles followed by a one-cycle hold gap.
// Optional macro WB_SRAM_CTRL_BURST_EN enables incrementing-burst reads.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   wb_stb_i/cyc_i/we_i        Wishbone strobe, cycle, write enable
//   wb_adr_i/sel_i/dat_i/cti_i byte address, selects, write data, cycle type
//   wb_dat_o, wb_ack_o         read data, one-cycle acknowledge per word
//   sram_adr/dat/be_n          SRAM address, data bus, byte enables
//   sram_ce_n/oe_n/we_n        SRAM chip, output and write enables
module wb_sram_ctrl
    import wb_sram_pkg::*;
#(
    parameter int ADR_WIDTH  = 18,
    parameter int SRAM_DW    = 16,
    parameter int RD_LATENCY = 0,
    parameter int WR_LATENCY = 0,
    localparam int LANES     = SRAM_DW / 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_we_i,
    input  logic [31:0]          wb_adr_i,
    input  logic [3:0]           wb_sel_i,
    input  logic [31:0]          wb_dat_i,
    input  logic [2:0]           wb_cti_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic [ADR_WIDTH-1:0] sram_adr,
    inout  wire  [SRAM_DW-1:0]   sram_dat,
    output logic [LANES-1:0]     sram_be_n,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n
);

    localparam int BEATS = 32 / SRAM_DW;
    localparam int BW    = beat_bits(BEATS);
    localparam int SHIFT = log2_ceil(BEATS);

    state_t               state_r, state_nxt_s;
    logic [BW-1:0]        beat_r, beat_nxt_s;
    logic [2:0]           wait_r, wait_nxt_s;
    logic [29:0]          word_r, word_nxt_s;
    logic                 load_s, cap_s, ack_nxt_s;
    logic                 bus_ok_s, req_s, last_beat_s, rd_end_s, wr_end_s;
    logic [31:0]          adr_calc_s, rd_rep_s, dat_o_nxt_s;
    logic [SRAM_DW-1:0]   lane_data_s, wdat_r;
    logic [LANES-1:0]     lane_be_n_s, be_n_r, be_n_nxt_s;
    logic [3:0]           rd_lane_we_s;
    logic                 ack_r, ce_n_r, oe_n_r, we_n_r, drive_r;
    logic                 ce_n_nxt_s, oe_n_nxt_s, we_n_nxt_s, drive_nxt_s;
    logic [31:0]          dat_o_r;
    logic [ADR_WIDTH-1:0] adr_r;
    logic                 in_unused_s;

    assign bus_ok_s    = wb_stb_i & wb_cyc_i;
    assign req_s       = bus_ok_s & ~ack_r;
    assign last_beat_s = (beat_r == BW'(BEATS - 1));
    assign rd_end_s    = (wait_r == 3'(RD_LATENCY));
    assign wr_end_s    = (wait_r == 3'(WR_LATENCY));
    // Word address times BEATS plus beat; the slice below truncates silently.
    assign adr_calc_s  = ({2'b00, word_nxt_s} << SHIFT) | 32'(beat_nxt_s);
    // Every beat lands in its own lane group, so replicating the bus lines
    // each lane up with its wb_dat_o position.
    assign rd_rep_s    = {BEATS{sram_dat}};

`ifdef WB_SRAM_CTRL_BURST_EN
    assign in_unused_s = ^wb_adr_i[1:0];
`else
    assign in_unused_s = ^{wb_cti_i, wb_adr_i[1:0]};
`endif

    wb_sram_lane_mux #(
        .SRAM_DW (SRAM_DW),
        .BW      (BW)
    ) u_lane_mux (
        .wr_beat    (beat_nxt_s),
        .rd_beat    (beat_r),
        .wr_data    (wb_dat_i),
        .wr_sel     (wb_sel_i),
        .lane_data  (lane_data_s),
        .lane_be_n  (lane_be_n_s),
        .rd_lane_we (rd_lane_we_s)
    );

    // FSM state register with beat, wait and word counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            beat_r  <= {BW{1'b0}};
            wait_r  <= 3'd0;
            word_r  <= 30'd0;
        end else begin
            state_r <= state_nxt_s;
            beat_r  <= beat_nxt_s;
            wait_r  <= wait_nxt_s;
            word_r  <= word_nxt_s;
        end
    end

    // Next-state logic; load_s marks edges that put a new beat on the pins.
    always_comb begin
        state_nxt_s = state_r;
        beat_nxt_s  = beat_r;
        wait_nxt_s  = wait_r;
        word_nxt_s  = word_r;
        load_s      = 1'b0;
        cap_s       = 1'b0;
        ack_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    word_nxt_s = wb_adr_i[31:2];
                    beat_nxt_s = {BW{1'b0}};
                    wait_nxt_s = 3'd0;
                    load_s     = 1'b1;
                    if (wb_we_i) begin
                        state_nxt_s = WR;
                    end else begin
                        state_nxt_s = RD;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD: begin
                if (rd_end_s) begin
                    cap_s      = 1'b1;
                    wait_nxt_s = 3'd0;
                    if (!last_beat_s) begin
                        beat_nxt_s = beat_r + BW'(1'b1);
                        load_s     = 1'b1;
                    end else begin
                        // A dropped strobe still lets the SRAM cycle end, just unacked.
                        ack_nxt_s   = bus_ok_s;
                        beat_nxt_s  = {BW{1'b0}};
                        state_nxt_s = IDLE;
`ifdef WB_SRAM_CTRL_BURST_EN
                        if (bus_ok_s && (wb_cti_i == CTI_INCR)) begin
                            state_nxt_s = RD;
                            word_nxt_s  = word_r + 30'd1;
                            load_s      = 1'b1;
                        end else begin
                            state_nxt_s = IDLE;
                        end
`endif
                    end
                end else begin
                    wait_nxt_s = wait_r + 3'd1;
                end
            end
            WR: begin
                if (wr_end_s) begin
                    state_nxt_s = WR_GAP;
                    wait_nxt_s  = 3'd0;
                end else begin
                    wait_nxt_s = wait_r + 3'd1;
                end
            end
            WR_GAP: begin
                if (!last_beat_s) begin
                    beat_nxt_s  = beat_r + BW'(1'b1);
                    wait_nxt_s  = 3'd0;
                    load_s      = 1'b1;
                    state_nxt_s = WR;
                end else begin
                    ack_nxt_s   = bus_ok_s;
                    beat_nxt_s  = {BW{1'b0}};
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Pin values for the coming cycle, decoded from the next state.
    always_comb begin
        ce_n_nxt_s  = (state_nxt_s == IDLE);
        oe_n_nxt_s  = (state_nxt_s != RD);
        we_n_nxt_s  = (state_nxt_s != WR);
        drive_nxt_s = (state_nxt_s == WR) || (state_nxt_s == WR_GAP);
        case (state_nxt_s)
            RD:      be_n_nxt_s = {LANES{1'b0}};
            WR:      be_n_nxt_s = load_s ? lane_be_n_s : be_n_r;
            WR_GAP:  be_n_nxt_s = be_n_r;
            default: be_n_nxt_s = {LANES{1'b1}};
        endcase
        dat_o_nxt_s = dat_o_r;
        for (int i = 0; i < 4; i++) begin
            if (cap_s && rd_lane_we_s[i]) begin
                dat_o_nxt_s[i*8 +: 8] = rd_rep_s[i*8 +: 8];
            end else begin
                dat_o_nxt_s[i*8 +: 8] = dat_o_r[i*8 +: 8];
            end
        end
    end

    // Output registers; reset forces the SRAM idle and releases the bus at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_r   <= 1'b0;
            dat_o_r <= 32'd0;
            adr_r   <= {ADR_WIDTH{1'b0}};
            be_n_r  <= {LANES{1'b1}};
            ce_n_r  <= 1'b1;
            oe_n_r  <= 1'b1;
            we_n_r  <= 1'b1;
            drive_r <= 1'b0;
            wdat_r  <= {SRAM_DW{1'b0}};
        end else begin
            ack_r   <= ack_nxt_s;
            dat_o_r <= dat_o_nxt_s;
            be_n_r  <= be_n_nxt_s;
            ce_n_r  <= ce_n_nxt_s;
            oe_n_r  <= oe_n_nxt_s;
            we_n_r  <= we_n_nxt_s;
            drive_r <= drive_nxt_s;
            if (load_s) begin
                adr_r  <= adr_calc_s[ADR_WIDTH-1:0];
                wdat_r <= lane_data_s;
            end else begin
                adr_r  <= adr_r;
                wdat_r <= wdat_r;
            end
        end
    end

    assign wb_ack_o  = ack_r;
    assign wb_dat_o  = dat_o_r;
    assign sram_adr  = adr_r;
    assign sram_be_n = be_n_r;
    assign sram_ce_n = ce_n_r;
    assign sram_oe_n = oe_n_r;
    assign sram_we_n = we_n_r;
    assign sram_dat  = drive_r ? wdat_r : {SRAM_DW{1'bz}};

endmodule
